// File: rtl/month_year_counter_pkg.sv
// Shared calendar definitions for month_year_counter and any display/alarm logic.
package month_year_counter_pkg;

    localparam logic [3:0]  MONTH_JAN     = 4'd1;
    localparam logic [3:0]  MONTH_FEB     = 4'd2;
    localparam logic [3:0]  MONTH_DEC     = 4'd12;

    localparam logic [5:0]  DAYS_28       = 6'd28;
    localparam logic [5:0]  DAYS_29       = 6'd29;
    localparam logic [5:0]  DAYS_30       = 6'd30;
    localparam logic [5:0]  DAYS_31       = 6'd31;

    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam logic [15:0] YEAR_MAX_BCD  = 16'h9999;

    // A two-digit BCD number is divisible by 4 iff (even tens, units 0/4/8) or (odd tens, units 2/6).
    function automatic logic leap_pair(input logic [3:0] tens, input logic [3:0] units);
        logic even_ok;
        logic odd_ok;
        even_ok = (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
        odd_ok  = (units == 4'd2) || (units == 4'd6);
        return tens[0] ? odd_ok : even_ok;
    endfunction

    // Century years defer to the thousands/hundreds pair (the divisible-by-400 rule).
    function automatic logic year_is_leap(input logic [15:0] year);
        if (year[7:0] == 8'h00)
            return leap_pair(year[15:12], year[11:8]);
        return leap_pair(year[7:4], year[3:0]);
    endfunction

    function automatic logic [5:0] month_days(input logic [3:0] month, input logic leap);
        case (month)
            MONTH_FEB:                   return leap ? DAYS_29 : DAYS_28;
            4'd4, 4'd6, 4'd9, 4'd11:     return DAYS_30;
            default:                     return DAYS_31;
        endcase
    endfunction

    // Out-of-range months (0, 13..15) recover to January on the next step.
    function automatic logic [3:0] month_up(input logic [3:0] month);
        if (month == 4'd0 || month >= MONTH_DEC)
            return MONTH_JAN;
        return month + 4'd1;
    endfunction

    function automatic logic [3:0] month_down(input logic [3:0] month);
        if (month == MONTH_JAN)
            return MONTH_DEC;
        if (month == 4'd0 || month > MONTH_DEC)
            return MONTH_JAN;
        return month - 4'd1;
    endfunction

endpackage

// File: rtl/month_year_counter_bcd_digit_updown.sv
// One BCD digit of an up/down ripple counter; ripple flags a 9->0 carry or 0->9 borrow.
module bcd_digit_updown
    import month_year_counter_pkg::*;
(
    input  logic       en_up,
    input  logic       en_dn,
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out,
    output logic       ripple
);

    // Next digit value; non-BCD codes recover to 0 without rippling.
    always_comb begin
        digit_out = digit_in;
        ripple    = 1'b0;
        if (en_up) begin
            if (digit_in >= BCD_MAX_DIGIT) begin
                digit_out = 4'd0;
                ripple    = (digit_in == BCD_MAX_DIGIT);
            end else begin
                digit_out = digit_in + 4'd1;
            end
        end else if (en_dn) begin
            if (digit_in == 4'd0) begin
                digit_out = BCD_MAX_DIGIT;
                ripple    = 1'b1;
            end else if (digit_in > BCD_MAX_DIGIT) begin
                digit_out = 4'd0;
            end else begin
                digit_out = digit_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/month_year_counter.sv
// Month (1..12) and BCD year (0000..9999) stage fed by the day-rollover pulse,
// with a manual set mode. Define MONTH_YEAR_LEAP_REG_EN to register
// is_leap_year and days_in_month (one cycle behind month/year changes).
module month_year_counter
    import month_year_counter_pkg::*;
#(
    parameter logic [3:0]  RESET_MONTH    = 4'd1,
    parameter logic [15:0] RESET_YEAR_BCD = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_set,
    input  logic        sel_year,
    input  logic        inc,
    input  logic        dec,
    input  logic        carry_in_day,
    output logic [3:0]  current_month,
    output logic [15:0] year_bcd,
    output logic        is_leap_year,
    output logic [5:0]  days_in_month,
    output logic        carry_out
);

    logic [3:0]  month_q;
    logic [3:0]  month_d;
    logic [15:0] year_q;
    logic [15:0] year_d;
    logic        run_step;
    logic        year_up;
    logic        year_dn;
    logic [3:0]  ripple;
    logic [3:0]  up_en;
    logic [3:0]  dn_en;

    // Decide which field moves this cycle; inc wins over dec in set mode.
    always_comb begin
        run_step = !ctrl_set && carry_in_day;
        year_up  = (run_step && month_q == MONTH_DEC) || (ctrl_set && sel_year && inc);
        year_dn  = ctrl_set && sel_year && !inc && dec;
        month_d  = month_q;
        if (run_step)
            month_d = month_up(month_q);
        else if (ctrl_set && !sel_year && inc)
            month_d = month_up(month_q);
        else if (ctrl_set && !sel_year && dec)
            month_d = month_down(month_q);
    end

    assign up_en = {ripple[2:0], 1'b1} & {4{year_up}};
    assign dn_en = {ripple[2:0], 1'b1} & {4{year_dn}};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_year_digit
            bcd_digit_updown u_digit (
                .en_up     (up_en[gi]),
                .en_dn     (dn_en[gi]),
                .digit_in  (year_q[4*gi +: 4]),
                .digit_out (year_d[4*gi +: 4]),
                .ripple    (ripple[gi])
            );
        end
    endgenerate

    // Month/year state; reset overrides any concurrent rollover or set strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            month_q <= RESET_MONTH;
            year_q  <= RESET_YEAR_BCD;
        end else begin
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

    // Top-digit ripple on a December rollover is exactly the 9999-12 wrap.
    assign carry_out     = rst_n && run_step && (month_q == MONTH_DEC) && year_up && ripple[3];
    assign current_month = month_q;
    assign year_bcd      = year_q;

`ifdef MONTH_YEAR_LEAP_REG_EN
    logic       leap_q;
    logic [5:0] dim_q;

    // Registered calendar flags, reset to values implied by the reset date.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leap_q <= year_is_leap(RESET_YEAR_BCD);
            dim_q  <= month_days(RESET_MONTH, year_is_leap(RESET_YEAR_BCD));
        end else begin
            leap_q <= year_is_leap(year_q);
            dim_q  <= month_days(month_q, year_is_leap(year_q));
        end
    end

    assign is_leap_year  = leap_q;
    assign days_in_month = dim_q;
`else
    assign is_leap_year  = year_is_leap(year_q);
    assign days_in_month = month_days(month_q, year_is_leap(year_q));
`endif

endmodule

// File: doc/month_year_counter.md
Name: month_year_counter

Overview:
- Calendar stage directly downstream of the day counter. It consumes the day-rollover pulse and advances month 1..12 and a 4-digit BCD year 0000..9999.
- Drives the day counter's current_month and is_leap_year inputs. Also provides the days-in-month value for the display and set logic.
- Supports a manual set mode (inc/dec on a selected field) that shares the same control strobes as the other time counters.

Parameters:
- RESET_MONTH, 1, month loaded at reset (1..12).
- RESET_YEAR_BCD, 16'h2000, year loaded at reset as 4 packed BCD digits (thousands in [15:12]).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- ctrl_set  input  1  1 = manual set mode; rollover input is ignored.
- sel_year  input  1  set-mode field select: 0 = month, 1 = year.
- inc  input  1  set-mode increment strobe, one cycle per step.
- dec  input  1  set-mode decrement strobe, one cycle per step.
- carry_in_day  input  1  one-cycle pulse from the day counter at the last day of the month.
- current_month  output  4  registered month, 1..12.
- year_bcd  output  16  registered year, packed BCD.
- is_leap_year  output  1  Gregorian leap flag for year_bcd.
- days_in_month  output  6  28/29/30/31 for current_month and is_leap_year.
- carry_out  output  1  millennium wrap pulse: 9999-12 rolls to 0000-01.

Behaviour:
- Reset (rst_n=0 at a clk edge): current_month=RESET_MONTH, year_bcd=RESET_YEAR_BCD. Outputs derived from these follow; carry_out=0 because carry_in_day has no effect during reset.
- Run mode (ctrl_set=0), on carry_in_day=1:
  - month<12: month+1.
  - month==12: month=1 and year+1 in BCD, with digits rippling 9->0 upward.
  - Year 9999 wraps to 0000.
  - Update is visible in the cycle after the pulse.
- Run mode: inc, dec and sel_year are ignored.
- Set mode (ctrl_set=1): carry_in_day is ignored.
  - inc has priority; inc and dec together means inc.
  - Month field: inc 12->1 and dec 1->12. Year is never touched.
  - Year field: BCD +1 / -1, wrapping 9999<->0000. Month is unchanged.
  - No carry_out is generated in set mode.
- carry_out is combinational: ctrl_set=0 AND carry_in_day AND month==12 AND year==16'h9999.
- is_leap_year (combinational by default), evaluated on the two-digit pairs:
  - pair divisible by 4: (tens even AND units in {0,4,8}) OR (tens odd AND units in {2,6}).
  - If tens/units != 00: leap = tens/units pair divisible by 4.
  - If tens/units == 00: leap = thousands/hundreds pair divisible by 4.
  - Examples: 2000 -> 1, 1900 -> 0, 2024 -> 1, 0000 -> 1.
- days_in_month: Feb = 29 if leap else 28; months 4/6/9/11 = 30; all others 31.
- Robustness: out-of-range month (0, 13..15) or non-BCD digits are not reachable after reset. If forced, the next step loads 1 (month) or 0 (digit).
- Reset mid-operation overrides everything in that cycle, including an active carry_in_day.
- The day counter samples the new month one cycle after its carry_out. Its day value is already 1 at that point, so no day clamp is required in run mode.

Optional Feature:
- Macro MONTH_YEAR_LEAP_REG_EN.
- Defined:
  - is_leap_year and days_in_month are registered, one cycle of latency after any year/month change.
  - Reset values are computed from the RESET_* parameters.
- Undefined: both outputs are purely combinational from the registered month and year.

Decomposition:
- Shared calendar package:
  - Month constants MONTH_JAN=1, MONTH_FEB=2, MONTH_DEC=12.
  - Day constants DAYS_28/29/30/31.
  - BCD_MAX_DIGIT=9, YEAR_MAX_BCD=16'h9999.
  - Leap-pair function, shared with any display or alarm logic.
- One sub-module: bcd_digit_updown.
  - Ports: en_up, en_dn, digit_in[3:0], digit_out[3:0], borrow/carry out.
  - Instantiated four times as a ripple chain for year_bcd.

Test Plan:
- Reset with defaults -> month=1, year=16'h2000, is_leap_year=1, days_in_month=31, carry_out=0.
- Start at 2023-12, pulse carry_in_day -> next cycle month=1, year=16'h2024, leap=1; then set month to 2 -> days_in_month=29.
- Start at 9999-12, ctrl_set=0, pulse carry_in_day -> carry_out=1 in the same cycle; next cycle month=1, year=16'h0000, leap=1.
- Set mode, sel_year=1, year=16'h1999, inc -> 16'h2000; dec twice -> 16'h1998.
  - Also load 1900 -> leap=0, Feb days_in_month=28.
- Set mode, sel_year=0, month=1:
  - dec -> 12.
  - inc and dec together -> 1.
  - carry_in_day pulsed in set mode -> no change, carry_out=0.
- Month=12, carry_in_day=1 with rst_n=0 in the same cycle -> reset values; no year increment.
